node_port_tx: RTL and testbench

Transmit end of the 4-bit inter-node port used by the async processor nodes. A node presents result nibbles on a valid/ready interface. The block buffers them in a small FIFO and delivers each nibble to a neighbour, which may be unclocked, over a 4-phase req/ack handshake. It sits between a node's `out` and a neighbour's A/B/C/D input when the link crosses a clock or asynchronous boundary.

---
 rtl/node_port_tx.sv | 186 ++++++++++++++++++
 tb/tb_node_port_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_port_tx.sv
// node_port_tx
// ------------
// Transmit end of the 4-bit inter-node port. Nibbles from the node arrive on a
// valid/ready interface and are buffered in a small FIFO. Each nibble is then
// sent to a neighbour, which may be unclocked, over a 4-phase req/ack
// handshake.
//
// Parameters:
//   DEPTH    FIFO entries, power of two, 2..16
//   TIMEOUT  cycles to wait on one ack phase before raising err, 1..255
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_data    nibble from the node
//   in_valid   in_data is valid
//   in_ready   FIFO not full
//   link_data  registered nibble to the neighbour
//   link_req   4-phase request, registered
//   link_ack   4-phase acknowledge, asynchronous to clk
//   link_par   even parity of link_data (0 when parity is not built)
//   level      current FIFO occupancy, 0..DEPTH
//   err        sticky handshake-timeout flag
//
// Optional feature: define NODE_PORT_TX_PARITY_EN to build the parity bit.

module node_port_tx #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] link_data,
  output logic       link_req,
  input  logic       link_ack,
  output logic       link_par,
  output logic [4:0] level,
  output logic       err
);

  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_LEVEL  = 5'(DEPTH);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          ack_meta;
  logic          ack_s;
  logic          push;
  logic          pop;
  logic          load;
  logic [7:0]    wait_cnt;
  logic [3:0]    head;

  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];

  // Two-flop synchronizer; link_ack may come from an unclocked neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= link_ack;
      ack_s    <= ack_meta;
    end
  end

  // Handshake sequencing. The FIFO head is popped when ack is seen in REQ.
  // From REL the next word can be launched directly without passing IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != 5'd0) begin
          load       = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          pop        = 1'b1;
          state_next = S_REL;
        end
      end
      S_REL: begin
        if (!ack_s) begin
          if (level != 5'd0) begin
            load       = 1'b1;
            state_next = S_REQ;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // link_data only moves on a load, which happens only as link_req rises,
  // so the data is stable for the whole time the request is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      link_req  <= 1'b0;
      link_data <= 4'd0;
    end else begin
      state    <= state_next;
      link_req <= (state_next == S_REQ);
      if (load) begin
        link_data <= head;
      end
    end
  end

  // Per-phase wait counter. It restarts on every state change, so err means
  // a single ack phase took TIMEOUT cycles. The FSM keeps waiting regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else if ((state_next != state) || (state == S_IDLE)) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != TIMEOUT_CNT) begin
      wait_cnt <= wait_cnt + 8'd1;
      if ((wait_cnt + 8'd1) == TIMEOUT_CNT) begin
        err <= 1'b1;
      end
    end
  end

`ifdef NODE_PORT_TX_PARITY_EN
  // Parity is loaded alongside link_data, so it obeys the same stability rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_par <= 1'b0;
    end else if (load) begin
      link_par <= ^head;
    end
  end
`else
  assign link_par = 1'b0;
`endif

endmodule

// File: tb/tb_node_port_tx.sv
// tb_node_port_tx
// ---------------
// Bench for node_port_tx (DEPTH=4, TIMEOUT=16). Accepted words are queued as
// expected deliveries. A monitor pops and compares on every link_req rise, and
// it checks that link_data holds while link_req is high. The neighbour is
// modelled either as a zero-delay loopback of link_req or as a forced ack
// level.

module tb_node_port_tx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
`ifdef NODE_PORT_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] link_data;
  logic       link_req;
  logic       link_ack;
  logic       link_par;
  logic [4:0] level;
  logic       err;
  logic       loop_en;
  logic       ack_force;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         push_cyc = 0;
  int         rise_count = 0;
  int         rise_cyc[$];
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp = 4'd0;
  logic       prev_req = 1'b0;

  node_port_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .link_data (link_data),
    .link_req  (link_req),
    .link_ack  (link_ack),
    .link_par  (link_par),
    .level     (level),
    .err       (err)
  );

  // The neighbour either echoes link_req with zero delay or holds a forced level.
  assign link_ack = loop_en ? link_req : ack_force;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic expPar(input logic [3:0] d);
    return PAR_ON ? ^d : 1'b0;
  endfunction

  function automatic int lastRise();
    return (rise_cyc.size() > 0) ? rise_cyc[rise_cyc.size()-1] : -100;
  endfunction

  // Sample point used by the main sequence: just after the falling edge.
  task automatic stepNeg();
    @(negedge clk);
    #1;
  endtask

  // Presents one word for a single clock edge; the expected handshake
  // readiness is supplied by the caller.
  task automatic applyStimulus(input logic [3:0] d, input logic accept);
    stepNeg();
    in_data  = d;
    in_valid = 1'b1;
    checkOutput("in_ready_at_push", 8'(in_ready), 8'(accept));
    @(posedge clk);
    if (accept) exp_q.push_back(d);
    #1;
    in_valid = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic waitRises(input int target, input int max_cycles);
    int n = 0;
    while (rise_count < target && n < max_cycles) begin
      stepNeg();
      n++;
    end
    if (rise_count < target) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_rise: got %0d requests within %0d cycles, required %0d",
               rise_count, max_cycles, target);
    end
  endtask

  // Scoreboard monitor: every request rise delivers the next expected word.
  always @(negedge clk) begin
    if (link_req && !prev_req) begin
      rise_count++;
      rise_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_word: got %0h required no request", link_data);
      end else begin
        cur_exp = exp_q.pop_front();
        checkOutput("word", 8'(link_data), 8'(cur_exp));
        checkOutput("word_par", 8'(link_par), 8'(expPar(cur_exp)));
      end
    end else if (link_req) begin
      checkOutput("data_stable", 8'(link_data), 8'(cur_exp));
    end
    prev_req = link_req;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p;
    int base;
    int r0;

    in_data   = 4'd0;
    in_valid  = 1'b0;
    loop_en   = 1'b0;
    ack_force = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    stepNeg();
    checkOutput("rst_link_req", 8'(link_req), 8'd0);
    checkOutput("rst_link_data", 8'(link_data), 8'd0);
    checkOutput("rst_link_par", 8'(link_par), 8'd0);
    checkOutput("rst_level", 8'(level), 8'd0);
    checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
    checkOutput("rst_err", 8'(err), 8'd0);

    // Single word with looped-back ack
    $display("[TB] single word 0x5");
    loop_en = 1'b1;
    base = rise_count;
    applyStimulus(4'h5, 1'b1);
    p = push_cyc;
    waitRises(base + 1, 10);
    checkOutput("req_latency", 8'(lastRise() - p), 8'd1);
    checkOutput("level_in_req", 8'(level), 8'd1);
    stepNeg();
    stepNeg();
    checkOutput("req_held", 8'(link_req), 8'd1);
    checkOutput("level_before_pop", 8'(level), 8'd1);
    stepNeg();
    checkOutput("req_released", 8'(link_req), 8'd0);
    checkOutput("level_after_pop", 8'(level), 8'd0);
    repeat (8) stepNeg();
    checkOutput("idle_req", 8'(link_req), 8'd0);

    // Back-to-back stream of four words
    $display("[TB] back-to-back 1,2,3,4");
    base = rise_count;
    applyStimulus(4'h1, 1'b1);
    p = push_cyc;
    applyStimulus(4'h2, 1'b1);
    applyStimulus(4'h3, 1'b1);
    applyStimulus(4'h4, 1'b1);
    waitRises(base + 4, 40);
    if (rise_cyc.size() >= base + 4) begin
      checkOutput("stream_latency", 8'(rise_cyc[base] - p), 8'd1);
      for (int k = 0; k < 3; k++)
        checkOutput("req_spacing", 8'(rise_cyc[base+k+1] - rise_cyc[base+k]), 8'd6);
    end
    repeat (10) stepNeg();
    checkOutput("stream_level", 8'(level), 8'd0);

    // Stalled neighbour: fill, reject, timeout, then drain
    $display("[TB] stalled ack, fill and timeout");
    loop_en   = 1'b0;
    ack_force = 1'b0;
    base = rise_count;
    applyStimulus(4'hA, 1'b1);
    p = push_cyc;
    applyStimulus(4'hB, 1'b1);
    applyStimulus(4'hC, 1'b1);
    applyStimulus(4'hD, 1'b1);
    applyStimulus(4'hE, 1'b0);
    checkOutput("full_level", 8'(level), 8'd4);
    checkOutput("full_ready", 8'(in_ready), 8'd0);
    checkOutput("one_request", 8'(rise_count - base), 8'd1);
    r0 = (rise_cyc.size() > base) ? rise_cyc[base] : p + 1;
    checkOutput("full_req_latency", 8'(r0 - p), 8'd1);
    while (cyc < r0 + TIMEOUT - 1) stepNeg();
    checkOutput("err_before_timeout", 8'(err), 8'd0);
    stepNeg();
    checkOutput("err_at_timeout", 8'(err), 8'd1);
    checkOutput("stall_req", 8'(link_req), 8'd1);
    checkOutput("stall_data", 8'(link_data), 8'hA);
    checkOutput("stall_level", 8'(level), 8'd4);
    loop_en = 1'b1;
    waitRises(base + 4, 40);
    repeat (12) stepNeg();
    checkOutput("drained_req", 8'(link_req), 8'd0);
    checkOutput("drained_level", 8'(level), 8'd0);
    checkOutput("err_sticky", 8'(err), 8'd1);

    // Reset in the middle of a handshake
    $display("[TB] reset during REQ");
    loop_en   = 1'b0;
    ack_force = 1'b0;
    base = rise_count;
    applyStimulus(4'h6, 1'b1);
    applyStimulus(4'h9, 1'b1);
    waitRises(base + 1, 10);
    stepNeg();
    checkOutput("queued_level", 8'(level), 8'd2);
    checkOutput("queued_req", 8'(link_req), 8'd1);
    checkOutput("err_before_reset", 8'(err), 8'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    stepNeg();
    checkOutput("mid_rst_req", 8'(link_req), 8'd0);
    checkOutput("mid_rst_level", 8'(level), 8'd0);
    checkOutput("mid_rst_err", 8'(err), 8'd0);
    checkOutput("mid_rst_ready", 8'(in_ready), 8'd1);
    ack_force = 1'b1;
    repeat (8) stepNeg();
    ack_force = 1'b0;
    repeat (8) stepNeg();
    checkOutput("no_send_after_rst", 8'(rise_count - base), 8'd1);
    checkOutput("post_rst_req", 8'(link_req), 8'd0);

    // Push on the same edge as the handshake pop
    $display("[TB] push and pop same edge");
    loop_en = 1'b1;
    base = rise_count;
    applyStimulus(4'hC, 1'b1);
    waitRises(base + 1, 10);
    checkOutput("pp_level_before", 8'(level), 8'd1);
    stepNeg();
    applyStimulus(4'hD, 1'b1);
    checkOutput("pp_level_same", 8'(level), 8'd1);
    checkOutput("pp_popped", 8'(link_req), 8'd0);
    waitRises(base + 2, 20);
    if (rise_cyc.size() >= base + 2)
      checkOutput("pp_spacing", 8'(rise_cyc[base+1] - rise_cyc[base]), 8'd6);
    repeat (10) stepNeg();
    checkOutput("pp_level_end", 8'(level), 8'd0);

    // Parity of 0x7 and 0x3
    $display("[TB] parity words 0x7, 0x3");
    base = rise_count;
    applyStimulus(4'h7, 1'b1);
    applyStimulus(4'h3, 1'b1);
    waitRises(base + 1, 10);
    checkOutput("par_first", 8'(link_par), 8'(PAR_ON));
    waitRises(base + 2, 20);
    checkOutput("par_second", 8'(link_par), 8'd0);
    repeat (10) stepNeg();
    checkOutput("final_level", 8'(level), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
